// File: rtl/multu_hilo_pkg.sv
// EX-stage shared definitions: ALU/multiplier funct codes and the
// multiplier FSM state encoding. The EX-stage ALU imports the same package.
package multu_hilo_pkg;

    // Funct field codes (instr[5:0]) decoded in the EX stage
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;

    // Sequential multiplier states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/multu_hilo.sv
// Unsigned shift-add multiplier with HI/LO registers for the EX stage.
// A MULTU funct in IDLE starts a WIDTH-cycle iterative multiply; the 2*WIDTH
// product is committed to HI/LO in the DONE cycle. MFHI/MFLO read back the
// committed HI/LO combinationally.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset
//   dataA   - multiplicand (rs)
//   dataB   - multiplier (rt)
//   Signal  - funct code (MULTU starts, MFHI/MFLO select readback)
//   dataOut - HI, LO or 0 depending on Signal
//   busy    - high in RUN and DONE
//   done    - one-cycle pulse following the HI/LO commit
module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    mul_state_e         state_q,  state_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Signal == FUNCT_MULTU) begin
                    mcand_d  = {{WIDTH{1'b0}}, dataA};
                    mplier_d = dataB;
                    prod_d   = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Last of WIDTH iterations is the one issued with cnt = WIDTH-1
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hi_d    = prod_q[2*WIDTH-1:WIDTH];
                lo_d    = prod_q[WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        dataOut = '0;
        if (Signal == FUNCT_MFHI) begin
            dataOut = hi_q;
        end else if (Signal == FUNCT_MFLO) begin
            dataOut = lo_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_multu_hilo.sv
// Bench for multu_hilo: table of directed products, random products against
// a plain-arithmetic reference, plus directed sequences for busy-ignore,
// mid-run reset, back-to-back issue and non-multiplier funct codes.
module tb_multu_hilo;
    import multu_hilo_pkg::*;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] dataA, dataB;
    logic [5:0]   Signal;
    logic [W-1:0] dataOut;
    logic         busy, done;

    int checks = 0;
    int failures = 0;

    multu_hilo #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
        .Signal(Signal), .dataOut(dataOut), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Called mid-cycle; MULTU is sampled at the next edge, then Signal drops.
    task automatic start_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        dataA = a; dataB = b; Signal = FUNCT_MULTU;
        @(posedge clk); #1;
        Signal = 6'd0;
    endtask

    // Returns edges counted from the start edge until done is seen high.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic read_hilo(output logic [2*W-1:0] p);
        Signal = FUNCT_MFLO; #1; p[W-1:0] = dataOut;
        Signal = FUNCT_MFHI; #1; p[2*W-1:W] = dataOut;
        Signal = 6'd0;
    endtask

    task automatic run_mult(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp);
        int lat;
        logic [2*W-1:0] p;
        start_mult(a, b);
        chk({nm, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({nm, "_latency"}, 64'(lat), 64'(LAT));
        read_hilo(p);
        chk({nm, "_hilo"}, p, exp);
    endtask

    initial begin
        int lat, pulses;
        logic [2*W-1:0] p;
        logic [W-1:0] ra, rb;

        tbl[0] = '{"m3x5",      32'd3,          32'd5,          64'h0000_0000_0000_000F};
        tbl[1] = '{"mffxff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        tbl[2] = '{"mx0",       32'h1234_5678,  32'd0,          64'd0};
        tbl[3] = '{"m2x8000",   32'd2,          32'h8000_0000,  64'h0000_0001_0000_0000};
        tbl[4] = '{"m10kx10k",  32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
        tbl[5] = '{"mabcd",     32'h0000_ABCD,  32'h0001_0001,  64'h0000_0000_ABCD_ABCD};

        reset = 1'b1; dataA = '0; dataB = '0; Signal = 6'd0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        read_hilo(p);
        chk("rst_hilo", p, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_mult(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].prod);
        end

        // Random products against the arithmetic reference
        for (int i = 0; i < 12; i++) begin
            ra = $urandom; rb = $urandom;
            if (i == 0) rb = 32'hFFFF_FFFF;
            run_mult("rand", ra, rb, {32'd0, ra} * {32'd0, rb});
        end

        // MULTU while busy is ignored; a single done pulse carries 3*5
        start_mult(32'd3, 32'd5);
        pulses = 0;
        for (int k = 2; k <= 45; k++) begin
            if (k >= 5 && k < 8) begin
                dataA = 32'd7; dataB = 32'd9; Signal = FUNCT_MULTU;
            end else begin
                Signal = 6'd0;
            end
            @(posedge clk); #1;
            if (done) pulses++;
        end
        Signal = 6'd0;
        chk("busy_ign_pulses", 64'(pulses), 64'd1);
        chk("busy_ign_idle", 64'(busy), 64'd0);
        read_hilo(p);
        chk("busy_ign_hilo", p, 64'h0000_0000_0000_000F);

        // Prime nonzero HI/LO, then ADD must read 0 and disturb nothing
        run_mult("prime", 32'hDEAD_BEEF, 32'h1234_5678, 64'hDEAD_BEEF * 64'h1234_5678);
        Signal = FUNCT_ADD; #1;
        chk("add_dout", 64'(dataOut), 64'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (busy || done) pulses++;
            chk("add_dout_hold", 64'(dataOut), 64'd0);
        end
        chk("add_no_start", 64'(pulses), 64'd0);
        read_hilo(p);
        chk("add_hilo", p, 64'hDEAD_BEEF * 64'h1234_5678);

        // Reset at RUN cycle 10 aborts: no done, HI/LO cleared
        start_mult(32'h0001_0000, 32'h0001_0000);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        #2 reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        read_hilo(p);
        chk("abort_hilo", p, 64'd0);

        // MULTU accepted on the first edge after reset release
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        run_mult("post_rst", 32'd11, 32'd13, 64'd143);

        // Back-to-back: second MULTU presented in the done cycle
        start_mult(32'h1234_5678, 32'd0);
        wait_done(lat);
        chk("b2b1_latency", 64'(lat), 64'(LAT));
        read_hilo(p);
        chk("b2b1_hilo", p, 64'd0);
        start_mult(32'd2, 32'h8000_0000);
        chk("b2b2_busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("b2b2_latency", 64'(lat), 64'(LAT));
        read_hilo(p);
        chk("b2b2_hilo", p, 64'h0000_0001_0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
